// File: rtl/vector_pixel_fetcher_if.sv
// vector_pixel_fetcher_if: frame control, vector-memory read and pixel stream signals
//   frame_start        : restart pulse into the fetcher
//   rd_req/rd_addr     : one-word read request to vector memory
//   rd_valid/rd_data   : read return, eight N-bit lanes, lane 0 leftmost
//   pix_valid/pix_ready/pix_data/line_end : pixel stream to the sink
//   frame_done         : pulse after the last pixel of a frame is accepted
interface vector_pixel_fetcher_if #(
  parameter int N = 20,
  parameter int AW = 16
);
  logic frame_start;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_valid;
  logic [8*N-1:0] rd_data;
  logic pix_valid;
  logic pix_ready;
  logic [7:0] pix_data;
  logic line_end;
  logic frame_done;
  modport master (
    input frame_start, rd_valid, rd_data, pix_ready,
    output rd_req, rd_addr, pix_valid, pix_data, line_end, frame_done
  );
  modport slave (
    output frame_start, rd_valid, rd_data, pix_ready,
    input rd_req, rd_addr, pix_valid, pix_data, line_end, frame_done
  );
endinterface

// File: rtl/vector_pixel_fetcher.sv
// vector_pixel_fetcher: fetches vector words into a ping-pong buffer and streams clamped 8-bit pixels
//   CLK   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : master side of vector_pixel_fetcher_if (memory read port + pixel stream)
module vector_pixel_fetcher #(
  parameter int N = 20,
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int AW = 16
)(
  input logic CLK,
  input logic reset,
  vector_pixel_fetcher_if.master bus
);
  localparam int WORDS = WIDTH * HEIGHT / 8;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XL = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YL = YW'(HEIGHT - 1);
  localparam logic [AW:0] WL = (AW + 1)'(WORDS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t st_q, st_d;
  logic [AW:0] word_q, word_d;
  logic out_q, out_d;
  logic [8*N-1:0] buf_q [2];
  logic [8*N-1:0] buf_d [2];
  logic [1:0] vld_q, vld_d;
  logic hd_q, hd_d;
  logic [2:0] ln_q, ln_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic done_q, done_d;

  logic [N-1:0] lane;
  logic acc, fill, pend, slot;

  assign lane = buf_q[hd_q][ln_q*N +: N];
  assign acc = vld_q[hd_q] && bus.pix_ready;
  // out_q guards against stale returns (after reset or a discarded flush read)
  assign fill = st_q == WAIT && out_q && bus.rd_valid;
  // a read is still in flight after this cycle
  assign pend = (out_q && !bus.rd_valid) || st_q == REQ;
  // the head slot is always the oldest entry, so an empty buffer fills at the head
  assign slot = vld_q[hd_q] ? ~hd_q : hd_q;

  assign bus.rd_req = st_q == REQ;
  assign bus.rd_addr = st_q == REQ ? word_q[AW-1:0] : '0;
  assign bus.pix_valid = vld_q[hd_q];
  assign bus.pix_data = !vld_q[hd_q] ? 8'd0 : lane[N-1] ? 8'd0 : lane > N'(255) ? 8'hff : lane[7:0];
  assign bus.line_end = vld_q[hd_q] && x_q == XL;
  assign bus.frame_done = done_q;

  always_comb begin
    st_d = st_q;
    word_d = word_q;
    out_d = pend;
    buf_d = buf_q;
    vld_d = vld_q;
    hd_d = hd_q;
    ln_d = ln_q;
    x_d = x_q;
    y_d = y_q;
    done_d = 1'b0;
    if (bus.frame_start) begin
      vld_d = '0;
      hd_d = 1'b0;
      ln_d = '0;
      x_d = '0;
      y_d = '0;
      word_d = '0;
      st_d = pend ? FLUSH : REQ;
    end else begin
      if (acc) begin
        ln_d = ln_q + 3'd1;
        if (ln_q == 3'd7) begin
          vld_d[hd_q] = 1'b0;
          hd_d = ~hd_q;
        end
        x_d = x_q == XL ? '0 : x_q + 1'b1;
        y_d = x_q != XL ? y_q : y_q == YL ? '0 : y_q + 1'b1;
        done_d = x_q == XL && y_q == YL;
      end
      if (fill) begin
        vld_d[slot] = 1'b1;
        buf_d[slot] = bus.rd_data;
      end
      word_d = st_q == REQ ? word_q + 1'b1 : word_q;
      // a new request only issues while a slot is free, so its return always has room
      st_d = st_q == REQ ? WAIT :
             st_q == FLUSH && !pend ? REQ :
             st_q == WAIT && !pend ? (word_q == WL ? IDLE : &vld_d ? WAIT : REQ) :
             st_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      st_q <= IDLE;
      word_q <= '0;
      out_q <= 1'b0;
      buf_q <= '{default: '0};
      vld_q <= '0;
      hd_q <= 1'b0;
      ln_q <= '0;
      x_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      word_q <= word_d;
      out_q <= out_d;
      buf_q <= buf_d;
      vld_q <= vld_d;
      hd_q <= hd_d;
      ln_q <= ln_d;
      x_q <= x_d;
      y_q <= y_d;
      done_q <= done_d;
    end
  end
endmodule
